trap_redirect_unit: RTL and testbench
=====================================

// Module: trap_redirect_unit
//
// PURPOSE
//  Consumer end of the CSR/EHU trap interface. Takes the EHU trap strobe
//  (initiate_exception) and committed MRET, then flushes the FD stage for a
//  fixed drain window. It then hands fetch a redirect PC through a
//  valid/ready handshake: csr_mtvec on a trap, csr_mepc on MRET. It also
//  tracks handler nesting and counts redirects. Sits between csr_ehu and
//  the fetch/PC logic.
//
// PARAMETERS
//  FLUSH_CYCLES  2  FD flush/stall cycles before redirect; legal range 0..15
//  CNT_W         8  width of trap_count
//
// PORTS
//  clk                 in   1      clock, rising edge
//  resetb              in   1      asynchronous, active-low reset
//  initiate_exception  in   1      trap strobe from csr_ehu; already qualified by ~XB_bubble
//  XB_mret             in   1      MRET committed in XB this cycle (not a bubble)
//  csr_mtvec           in   32     trap vector base from csr_ehu
//  csr_mepc            in   32     exception PC from csr_ehu
//  redirect_ready      in   1      fetch accepts redirect_pc this cycle
//  redirect_valid      out  1      redirect_pc is valid; held until accepted
//  redirect_pc         out  32     target PC; bits [1:0] always 0
//  flush_FD            out  1      kill the instruction in FD; force a bubble into XB
//  stall_fetch         out  1      freeze PC/fetch
//  in_handler          out  1      1 between a trap redirect and the matching MRET redirect
//  double_fault        out  1      sticky: trap accepted while in_handler = 1
//  lost_event          out  1      sticky: trap/MRET strobe arrived while state != IDLE
//  trap_count          out  CNT_W  number of completed trap redirects; wraps
//
// BEHAVIOUR
//  Reset: state = IDLE; all outputs 0; redirect_pc = 0; internal target and
//   flush counter = 0. Reset in mid-sequence aborts the sequence; no redirect
//   is issued.
//  Events are sampled on the rising clk edge and only in IDLE.
//   initiate_exception has priority over XB_mret when both are high; the
//   MRET is dropped and lost_event is NOT set.
//  Target capture is registered on the event edge:
//   - trap: target = {csr_mtvec[31:2], 2'b00}; kind = TRAP
//   - MRET: target = {csr_mepc[31:2], 2'b00}; kind = RET
//  IDLE -> FLUSH when FLUSH_CYCLES > 0; the counter loads FLUSH_CYCLES-1.
//   IDLE -> REDIRECT directly when FLUSH_CYCLES == 0.
//  FLUSH: flush_FD = 1 and stall_fetch = 1, both registered outputs. The
//   counter decrements each cycle. At 0, go to REDIRECT. FLUSH lasts exactly
//   FLUSH_CYCLES cycles.
//  REDIRECT: redirect_valid = 1, redirect_pc = target, stall_fetch = 1,
//   flush_FD = 1.
//   - redirect_pc is stable while valid && !ready.
//   - valid is never withdrawn before acceptance.
//   - Handshake when valid & ready; the next state is IDLE and all three
//     outputs drop the following cycle.
//   - Redirect latency, event edge to first valid cycle: FLUSH_CYCLES + 1 cycles.
//  On handshake:
//   - TRAP: trap_count += 1 (mod 2^CNT_W); in_handler <= 1.
//   - RET: in_handler <= 0; trap_count unchanged.
//  double_fault sets when a trap is captured in IDLE while in_handler = 1.
//   The trap still proceeds normally.
//  lost_event sets when either strobe is high in FLUSH or REDIRECT. The
//   event is otherwise ignored.
//  Sticky flags clear only on reset.
//  An MRET captured with in_handler = 0 is legal: it redirects to mepc and
//   in_handler stays 0.
//
// TESTING
//  1. mtvec=0x0000_0104, pulse initiate_exception, ready=1, FLUSH_CYCLES=2
//     -> flush_FD/stall_fetch high for cycles +1..+3; valid on cycle +3 only
//     with pc=0x104; trap_count=1; in_handler=1.
//  2. After 1: mepc=0x0000_2002, pulse XB_mret, hold ready=0 for 4 cycles
//     -> valid held with pc=0x2000 throughout; accepted on the cycle ready=1;
//     in_handler=0; trap_count stays 1.
//  3. Exception and MRET in the same cycle
//     -> redirect to mtvec; lost_event=0; trap_count increments.
//  4. Strobe during FLUSH -> lost_event=1; a second trap while in_handler=1
//     -> double_fault=1 and trap_count increments; CNT_W=8 with 256 traps
//     -> trap_count wraps to 0.
//  5. Assert resetb=0 during REDIRECT with ready=0
//     -> all outputs 0 asynchronously; after release, idle with no redirect.
//     Rerun with FLUSH_CYCLES=0 -> valid on cycle +1 and flush_FD only while
//     valid.

Source files
------------

// File: rtl/trap_redirect_unit.sv
// Trap/MRET consumer: flushes FD for a drain window, then hands fetch a
// redirect PC (mtvec on trap, mepc on MRET) over a valid/ready handshake.
//
// Ports:
//   clk, resetb          clock, async active-low reset
//   initiate_exception   trap strobe from csr_ehu
//   XB_mret              committed MRET strobe
//   csr_mtvec, csr_mepc  redirect sources
//   redirect_ready       fetch accepts redirect this cycle
//   redirect_valid/pc    redirect handshake toward fetch
//   flush_FD, stall_fetch pipeline control during the sequence
//   in_handler           inside a trap handler
//   double_fault         sticky: trap taken while in_handler
//   lost_event           sticky: strobe seen outside IDLE
//   trap_count           completed trap redirects, wraps
module trap_redirect_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             initiate_exception,
  input  logic             XB_mret,
  input  logic [31:0]      csr_mtvec,
  input  logic [31:0]      csr_mepc,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_FD,
  output logic             stall_fetch,
  output logic             in_handler,
  output logic             double_fault,
  output logic             lost_event,
  output logic [CNT_W-1:0] trap_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD =
    4'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [31:0] target;
  logic [31:0] target_n;
  logic        kind_trap;
  logic        kind_n;

  logic        ev_trap;
  logic        ev_ret;
  logic        hs;
  logic        strobe;

  // Low PC bits are forced to zero on capture.
  logic        unused_lsbs;
  assign unused_lsbs = ^{csr_mtvec[1:0], csr_mepc[1:0]};

  assign strobe  = initiate_exception | XB_mret;
  // Trap wins a tie with MRET; the MRET is silently dropped.
  assign ev_trap = (state == IDLE) & initiate_exception;
  assign ev_ret  = (state == IDLE) & ~initiate_exception & XB_mret;
  assign hs      = redirect_valid & redirect_ready;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    target_n = target;
    kind_n   = kind_trap;
    unique case (state)
      IDLE: begin
        if (ev_trap | ev_ret) begin
          kind_n   = ev_trap;
          target_n = ev_trap ? {csr_mtvec[31:2], 2'b00}
                             : {csr_mepc[31:2], 2'b00};
          if (FLUSH_CYCLES > 0) begin
            state_n = FLUSH;
            cnt_n   = FLUSH_LOAD;
          end else begin
            state_n = REDIRECT;
          end
        end
      end
      FLUSH: begin
        if (cnt == 4'd0) begin
          state_n = REDIRECT;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      REDIRECT: begin
        if (hs) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      cnt       <= '0;
      target    <= '0;
      kind_trap <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      target    <= target_n;
      kind_trap <= kind_n;
    end
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_FD       <= 1'b0;
      stall_fetch    <= 1'b0;
    end else begin
      redirect_valid <= (state_n == REDIRECT);
      redirect_pc    <= (state_n == REDIRECT) ? target_n : '0;
      flush_FD       <= (state_n != IDLE);
      stall_fetch    <= (state_n != IDLE);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      in_handler   <= 1'b0;
      double_fault <= 1'b0;
      lost_event   <= 1'b0;
      trap_count   <= '0;
    end else begin
      if (hs) begin
        in_handler <= kind_trap;
        if (kind_trap) begin
          trap_count <= trap_count + CNT_W'(1);
        end
      end
      if (ev_trap & in_handler) begin
        double_fault <= 1'b1;
      end
      if ((state != IDLE) & strobe) begin
        lost_event <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trap_redirect_unit.sv
// Bench for trap_redirect_unit: two instances (2-cycle and 0-cycle flush),
// redirect PCs checked by scoreboard monitors, status checked inline.
module tb_trap_redirect_unit;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;

  logic        exc0 = 0, mret0 = 0, rdy0 = 1;
  logic [31:0] mtvec0 = 0, mepc0 = 0;
  logic        val0, flush0, stall0, inh0, df0, lost0;
  logic [31:0] pc0;
  logic [7:0]  cnt0;

  logic        exc1 = 0, mret1 = 0, rdy1 = 1;
  logic [31:0] mtvec1 = 0, mepc1 = 0;
  logic        val1, flush1, stall1, inh1, df1, lost1;
  logic [31:0] pc1;
  logic [7:0]  cnt1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  trap_redirect_unit #(.FLUSH_CYCLES(2), .CNT_W(8)) u0 (
    .clk(clk), .resetb(resetb),
    .initiate_exception(exc0), .XB_mret(mret0),
    .csr_mtvec(mtvec0), .csr_mepc(mepc0),
    .redirect_ready(rdy0), .redirect_valid(val0),
    .redirect_pc(pc0), .flush_FD(flush0),
    .stall_fetch(stall0), .in_handler(inh0),
    .double_fault(df0), .lost_event(lost0),
    .trap_count(cnt0)
  );

  trap_redirect_unit #(.FLUSH_CYCLES(0), .CNT_W(8)) u1 (
    .clk(clk), .resetb(resetb),
    .initiate_exception(exc1), .XB_mret(mret1),
    .csr_mtvec(mtvec1), .csr_mepc(mepc1),
    .redirect_ready(rdy1), .redirect_valid(val1),
    .redirect_pc(pc1), .flush_FD(flush1),
    .stall_fetch(stall1), .in_handler(inh1),
    .double_fault(df1), .lost_event(lost1),
    .trap_count(cnt1)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetb && val0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u0_unexpected_valid: got pc %h expected none", pc0);
      end else begin
        chk("u0_redirect_pc", pc0, q0[0]);
        if (rdy0) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (resetb && val1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u1_unexpected_valid: got pc %h expected none", pc1);
      end else begin
        chk("u1_redirect_pc", pc1, q1[0]);
        if (rdy1) void'(q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full trap/MRET sequence on u0 with ready held high.
  task automatic ev0(input logic e, input logic m,
                     input logic [31:0] tv, input logic [31:0] ep,
                     input logic [31:0] exp_pc);
    mtvec0 = tv;
    mepc0  = ep;
    exc0   = e;
    mret0  = m;
    q0.push_back(exp_pc);
    tick();
    exc0  = 0;
    mret0 = 0;
    repeat (3) tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", {31'd0, val0}, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_flush", {31'd0, flush0}, 0);
    chk("rst_stall", {31'd0, stall0}, 0);
    chk("rst_count", {24'd0, cnt0}, 0);
    chk("rst_inh", {31'd0, inh0}, 0);
    resetb = 1;
    tick();

    // 1: trap, ready high
    mtvec0 = 32'h0000_0104;
    exc0 = 1;
    q0.push_back(32'h0000_0104);
    tick();
    exc0 = 0;
    chk("t1_c1_flush", {31'd0, flush0}, 1);
    chk("t1_c1_stall", {31'd0, stall0}, 1);
    chk("t1_c1_valid", {31'd0, val0}, 0);
    tick();
    chk("t1_c2_flush", {31'd0, flush0}, 1);
    chk("t1_c2_valid", {31'd0, val0}, 0);
    tick();
    chk("t1_c3_flush", {31'd0, flush0}, 1);
    chk("t1_c3_valid", {31'd0, val0}, 1);
    tick();
    chk("t1_c4_valid", {31'd0, val0}, 0);
    chk("t1_c4_flush", {31'd0, flush0}, 0);
    chk("t1_c4_stall", {31'd0, stall0}, 0);
    chk("t1_count", {24'd0, cnt0}, 1);
    chk("t1_inh", {31'd0, inh0}, 1);

    // 2: MRET with ready low for 4 cycles
    rdy0 = 0;
    mepc0 = 32'h0000_2002;
    mret0 = 1;
    q0.push_back(32'h0000_2000);
    tick();
    mret0 = 0;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_held_valid", {31'd0, val0}, 1);
      chk("t2_held_pc", pc0, 32'h0000_2000);
      if (i < 3) tick();
    end
    rdy0 = 1;
    tick();
    chk("t2_done_valid", {31'd0, val0}, 0);
    chk("t2_inh", {31'd0, inh0}, 0);
    chk("t2_count", {24'd0, cnt0}, 1);

    // 3: exception and MRET together
    ev0(1, 1, 32'h0000_0300, 32'h0000_5554, 32'h0000_0300);
    chk("t3_lost", {31'd0, lost0}, 0);
    chk("t3_count", {24'd0, cnt0}, 2);
    chk("t3_inh", {31'd0, inh0}, 1);
    chk("t3_df", {31'd0, df0}, 0);

    // 4a: nested trap plus strobe during FLUSH
    mtvec0 = 32'h0000_040B;
    exc0 = 1;
    q0.push_back(32'h0000_0408);
    tick();
    exc0 = 0;
    mret0 = 1;
    tick();
    mret0 = 0;
    chk("t4_lost", {31'd0, lost0}, 1);
    chk("t4_df", {31'd0, df0}, 1);
    repeat (2) tick();
    chk("t4_count", {24'd0, cnt0}, 3);
    chk("t4_inh", {31'd0, inh0}, 1);

    // 4b: wrap trap_count from 3 through 255 back to 0
    for (int i = 0; i < 253; i++) begin
      ev0(1, 0, 32'h0001_0003 + 32'(i * 16), 0,
          32'h0001_0000 + 32'(i * 16));
    end
    chk("t4_wrap", {24'd0, cnt0}, 0);
    chk("t4_df_sticky", {31'd0, df0}, 1);
    chk("t4_lost_sticky", {31'd0, lost0}, 1);

    // 5: reset during REDIRECT with ready low
    rdy0 = 0;
    mtvec0 = 32'h0000_0800;
    exc0 = 1;
    q0.push_back(32'h0000_0800);
    tick();
    exc0 = 0;
    repeat (2) tick();
    chk("t5_pre_valid", {31'd0, val0}, 1);
    #2;
    resetb = 0;
    #1;
    chk("t5_valid", {31'd0, val0}, 0);
    chk("t5_pc", pc0, 0);
    chk("t5_flush", {31'd0, flush0}, 0);
    chk("t5_stall", {31'd0, stall0}, 0);
    chk("t5_inh", {31'd0, inh0}, 0);
    chk("t5_df", {31'd0, df0}, 0);
    chk("t5_lost", {31'd0, lost0}, 0);
    chk("t5_count", {24'd0, cnt0}, 0);
    q0.delete();
    tick();
    tick();
    resetb = 1;
    rdy0 = 1;
    repeat (4) tick();
    chk("t5_idle_valid", {31'd0, val0}, 0);
    chk("t5_idle_flush", {31'd0, flush0}, 0);

    // 5b: FLUSH_CYCLES = 0 instance
    mtvec1 = 32'h0000_0A0B;
    exc1 = 1;
    q1.push_back(32'h0000_0A08);
    tick();
    exc1 = 0;
    chk("z_c1_valid", {31'd0, val1}, 1);
    chk("z_c1_flush", {31'd0, flush1}, 1);
    chk("z_c1_stall", {31'd0, stall1}, 1);
    tick();
    chk("z_c2_valid", {31'd0, val1}, 0);
    chk("z_c2_flush", {31'd0, flush1}, 0);
    chk("z_count", {24'd0, cnt1}, 1);
    chk("z_inh", {31'd0, inh1}, 1);
    rdy1 = 0;
    mepc1 = 32'h0000_3333;
    mret1 = 1;
    q1.push_back(32'h0000_3330);
    tick();
    mret1 = 0;
    chk("z_ret_valid", {31'd0, val1}, 1);
    tick();
    chk("z_ret_held", {31'd0, val1}, 1);
    chk("z_ret_flush", {31'd0, flush1}, 1);
    rdy1 = 1;
    tick();
    chk("z_ret_done", {31'd0, val1}, 0);
    chk("z_ret_flush0", {31'd0, flush1}, 0);
    chk("z_ret_inh", {31'd0, inh1}, 0);
    chk("z_ret_count", {24'd0, cnt1}, 1);
    chk("z_lost", {31'd0, lost1}, 0);

    tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
